// File: rtl/drp_rmw_seq.sv
// DRP read-modify-write sequencer: on each accepted drp_start it walks a parameter
// table of (address, mask, data) entries, reading, merging and writing back each one.
module drp_rmw_seq #(
  parameter int                        NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*7-1:0]  ADDR_TABLE  = '0,
  parameter logic [NUM_ENTRIES*16-1:0] MASK_TABLE  = '0,
  parameter logic [NUM_ENTRIES*16-1:0] DATA_TABLE  = '0,
  parameter int                        TIMEOUT     = 255
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        drp_start,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_t;

  localparam logic [3:0] LAST_IDX    = 4'(NUM_ENTRIES - 1);
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  // Tables are unpacked to 16 slots so a 4-bit index always fits; unused slots read 0.
  logic [6:0]  w_addrArr [16];
  logic [15:0] w_maskArr [16];
  logic [15:0] w_dataArr [16];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_ENTRIES) begin : g_used
      assign w_addrArr[g] = ADDR_TABLE[7*g +: 7];
      assign w_maskArr[g] = MASK_TABLE[16*g +: 16];
      assign w_dataArr[g] = DATA_TABLE[16*g +: 16];
    end else begin : g_unused
      assign w_addrArr[g] = '0;
      assign w_maskArr[g] = '0;
      assign w_dataArr[g] = '0;
    end
  end

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [6:0]  r_daddr;
  logic [15:0] r_di;
  logic        r_den;
  logic        r_dwe;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  state_t      w_stateNext;
  logic [3:0]  w_idxNext;
  logic [7:0]  w_cntNext;
  logic [6:0]  w_daddrNext;
  logic [15:0] w_diNext;
  logic        w_denNext;
  logic        w_dweNext;
  logic        w_busyNext;
  logic        w_doneNext;
  logic        w_errorNext;
  logic [7:0]  w_cntInc;
  logic [15:0] w_merged;

  // The compare uses the post-increment count so the abort lands TIMEOUT cycles
  // after entering the wait state.
  assign w_cntInc = r_cnt + 8'd1;
  assign w_merged = (drp_do & ~w_maskArr[r_idx]) | (w_dataArr[r_idx] & w_maskArr[r_idx]);

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_cntNext   = r_cnt;
    w_daddrNext = r_daddr;
    w_diNext    = r_di;
    w_denNext   = 1'b0;
    w_dweNext   = 1'b0;
    w_doneNext  = 1'b0;
    w_errorNext = r_error;
    case (r_state)
      S_IDLE: begin
        if (drp_start) begin
          w_stateNext = S_RD_REQ;
          w_idxNext   = 4'd0;
          w_cntNext   = 8'd0;
          w_errorNext = 1'b0;
          w_denNext   = 1'b1;
          w_daddrNext = w_addrArr[0];
        end
      end
      S_RD_REQ: begin
        w_stateNext = S_RD_WAIT;
        w_cntNext   = 8'd0;
      end
      S_WR_REQ: begin
        w_stateNext = S_WR_WAIT;
        w_cntNext   = 8'd0;
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (drdy) begin
          if (r_state == S_RD_WAIT) begin
            w_stateNext = S_WR_REQ;
            w_denNext   = 1'b1;
            w_dweNext   = 1'b1;
            w_daddrNext = w_addrArr[r_idx];
            w_diNext    = w_merged;
          end else if (r_idx == LAST_IDX) begin
            w_stateNext = S_IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext = S_RD_REQ;
            w_idxNext   = r_idx + 4'd1;
            w_denNext   = 1'b1;
            w_daddrNext = w_addrArr[r_idx + 4'd1];
          end
        end else if (w_cntInc == TIMEOUT_VAL) begin
          w_stateNext = S_IDLE;
          w_errorNext = 1'b1;
          w_doneNext  = 1'b1;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
    w_busyNext = (w_stateNext != S_IDLE);
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 8'd0;
      r_daddr <= 7'd0;
      r_di    <= 16'd0;
      r_den   <= 1'b0;
      r_dwe   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_cnt   <= w_cntNext;
      r_daddr <= w_daddrNext;
      r_di    <= w_diNext;
      r_den   <= w_denNext;
      r_dwe   <= w_dweNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
      r_error <= w_errorNext;
    end
  end

  assign daddr = r_daddr;
  assign di    = r_di;
  assign den   = r_den;
  assign dwe   = r_dwe;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

endmodule

// File: tb/tb_drp_rmw_seq.sv
// Bench for drp_rmw_seq: a DRP memory model answers requests and a queue holds
// the bus transactions the sequencer is expected to issue, in order.
module tb_drp_rmw_seq;

  localparam int N  = 4;
  localparam int TO = 10;
  localparam logic [N*7-1:0]  ADDRS = {7'h00, 7'h7F, 7'h05, 7'h1A};
  localparam logic [N*16-1:0] MASKS = {16'hFFFF, 16'h0000, 16'hFF00, 16'h00F0};
  localparam logic [N*16-1:0] DATAS = {16'h5A5A, 16'hFFFF, 16'h1200, 16'h0050};

  typedef struct packed {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
  } txn_t;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic        drp_start;
  logic        drdy;
  logic [15:0] drp_do;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den;
  logic        dwe;
  logic        busy;
  logic        done;
  logic        error;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int denCount    = 0;
  int doneCount   = 0;

  txn_t        expQ [$];
  txn_t        monExp;
  logic [6:0]  tAddr [N];
  logic [15:0] tMask [N];
  logic [15:0] tData [N];
  logic [15:0] mem [128];

  drp_rmw_seq #(
    .NUM_ENTRIES(N),
    .ADDR_TABLE (ADDRS),
    .MASK_TABLE (MASKS),
    .DATA_TABLE (DATAS),
    .TIMEOUT    (TO)
  ) u_dut (
    .clkin    (clkin),
    .reset_n  (reset_n),
    .drp_start(drp_start),
    .drp_do   (drp_do),
    .drdy     (drdy),
    .daddr    (daddr),
    .di       (di),
    .den      (den),
    .dwe      (dwe),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every den pulse must match the head of the expected queue.
  always @(negedge clkin) begin
    if (den === 1'b1) begin
      denCount++;
      checkOutput("den_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("den_addr", 32'(daddr), 32'(monExp.addr));
        checkOutput("den_we", 32'(dwe), 32'(monExp.we));
        if (monExp.we) checkOutput("wr_data", 32'(di), 32'(monExp.di));
      end
    end else begin
      checkOutput("dwe_without_den", 32'(dwe), 32'd0);
    end
    if (done === 1'b1) doneCount++;
  end

  task automatic applyStimulus(input int nTxn, input bit immediate, output int startCyc);
    txn_t t;
    for (int i = 0; i < N; i++) begin
      t.addr = tAddr[i];
      t.we   = 1'b0;
      t.di   = 16'h0000;
      if (2*i < nTxn) expQ.push_back(t);
      t.we = 1'b1;
      t.di = (mem[tAddr[i]] & ~tMask[i]) | (tData[i] & tMask[i]);
      if (2*i + 1 < nTxn) expQ.push_back(t);
    end
    if (!immediate) begin
      @(posedge clkin);
      #1;
    end
    drp_start = 1'b1;
    startCyc  = cycle;
    @(posedge clkin);
    #1;
    drp_start = 1'b0;
  endtask

  task automatic serve(input int lat, input bit respond, input bit poke,
                       output int denCyc, output logic [15:0] seenDi);
    bit         seen;
    logic [6:0] a;
    logic       w;
    seen   = 1'b0;
    denCyc = -1;
    seenDi = 16'h0000;
    a      = 7'h00;
    w      = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clkin);
      if (den === 1'b1) begin
        seen   = 1'b1;
        denCyc = cycle;
        seenDi = di;
        a      = daddr;
        w      = dwe;
      end
    end
    checkOutput("den_arrives", 32'(seen), 32'd1);
    if (seen && respond) begin
      for (int k = 0; k < lat; k++) begin
        @(posedge clkin);
        #1;
        drp_start = poke && (k == 0);
      end
      drp_start = 1'b0;
      drdy      = 1'b1;
      drp_do    = w ? 16'hDEAD : mem[a];
      if (w) mem[a] = seenDi;
      @(posedge clkin);
      #1;
      drdy   = 1'b0;
      drp_do = 16'h0000;
    end
  endtask

  task automatic waitDone(output int doneCyc);
    bit seen;
    seen    = 1'b0;
    doneCyc = -1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clkin);
      if (done === 1'b1) begin
        seen    = 1'b1;
        doneCyc = cycle;
      end
    end
    checkOutput("done_arrives", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sc, dc, dcyc, n0, d0;
    logic [15:0] sdi;
    int          lats [8];
    lats = '{1, 3, 5, 2, 4, 1, 2, 5};

    reset_n   = 1'b0;
    drp_start = 1'b0;
    drdy      = 1'b0;
    drp_do    = 16'h0000;
    for (int i = 0; i < N; i++) begin
      tAddr[i] = ADDRS[7*i +: 7];
      tMask[i] = MASKS[16*i +: 16];
      tData[i] = DATAS[16*i +: 16];
    end
    for (int a = 0; a < 128; a++) mem[a] = 16'(a * 257);
    mem[7'h1A] = 16'hABCD;
    mem[7'h05] = 16'h3456;
    mem[7'h7F] = 16'h0F0F;
    mem[7'h00] = 16'h1111;

    // Reset values and a quiet idle period.
    repeat (3) @(posedge clkin);
    #1;
    checkOutput("reset_outs", 32'({daddr, di, den, dwe, busy, done, error}), 32'd0);
    reset_n = 1'b1;
    n0 = denCount;
    repeat (20) @(posedge clkin);
    #1;
    checkOutput("idle_den_count", 32'(denCount - n0), 32'd0);
    checkOutput("idle_outs", 32'({daddr, di, den, dwe, busy, done, error}), 32'd0);

    // Full table, drdy one cycle after every den.
    n0 = denCount;
    d0 = doneCount;
    applyStimulus(8, 1'b0, sc);
    checkOutput("start_den", 32'({den, dwe, busy}), 32'b101);
    checkOutput("start_addr", 32'(daddr), 32'h1A);
    serve(1, 1'b1, 1'b0, dcyc, sdi);
    serve(1, 1'b1, 1'b0, dcyc, sdi);
    checkOutput("wr0_di", 32'(sdi), 32'hAB5D);
    for (int k = 2; k < 2*N; k++) serve(1, 1'b1, 1'b0, dcyc, sdi);
    waitDone(dc);
    checkOutput("done_latency", 32'(dc - sc), 32'(4*N + 1));
    checkOutput("done_flags", 32'({busy, error}), 32'd0);
    #1;
    checkOutput("seqA_dens", 32'(denCount - n0), 32'(2*N));
    checkOutput("seqA_dones", 32'(doneCount - d0), 32'd1);
    checkOutput("seqA_sb_empty", 32'(expQ.size()), 32'd0);

    // Variable drdy latency, then a start in the done cycle, with a second
    // start pulsed while that next sequence is busy.
    n0 = denCount;
    d0 = doneCount;
    applyStimulus(8, 1'b0, sc);
    for (int k = 0; k < 2*N; k++) serve(lats[k], 1'b1, 1'b0, dcyc, sdi);
    checkOutput("seqB_done", 32'({done, busy, error}), 32'b100);
    checkOutput("seqB_dens", 32'(denCount - n0), 32'(2*N));
    applyStimulus(8, 1'b1, sc);
    checkOutput("b2b_start_den", 32'({den, busy}), 32'b11);
    serve(3, 1'b1, 1'b1, dcyc, sdi);
    for (int k = 1; k < 2*N; k++) serve(1, 1'b1, 1'b0, dcyc, sdi);
    waitDone(dc);
    checkOutput("seqC_error", 32'(error), 32'd0);
    repeat (10) @(posedge clkin);
    #1;
    checkOutput("seqBC_dens", 32'(denCount - n0), 32'(4*N));
    checkOutput("seqBC_dones", 32'(doneCount - d0), 32'd2);
    checkOutput("seqBC_idle", 32'({busy, den}), 32'd0);
    checkOutput("seqBC_sb_empty", 32'(expQ.size()), 32'd0);

    // Withhold drdy on the entry-1 write.
    applyStimulus(4, 1'b0, sc);
    serve(1, 1'b1, 1'b0, dcyc, sdi);
    serve(1, 1'b1, 1'b0, dcyc, sdi);
    serve(2, 1'b1, 1'b0, dcyc, sdi);
    serve(0, 1'b0, 1'b0, dcyc, sdi);
    waitDone(dc);
    checkOutput("timeout_latency", 32'(dc - dcyc), 32'(TO + 1));
    checkOutput("timeout_flags", 32'({done, error, busy}), 32'b110);
    @(posedge clkin);
    #1;
    drdy = 1'b1;
    @(posedge clkin);
    #1;
    drdy = 1'b0;
    n0 = denCount;
    d0 = doneCount;
    repeat (5) @(posedge clkin);
    #1;
    checkOutput("late_drdy_dens", 32'(denCount - n0), 32'd0);
    checkOutput("late_drdy_dones", 32'(doneCount - d0), 32'd0);
    checkOutput("error_sticky", 32'({error, busy}), 32'b10);
    checkOutput("timeout_sb_empty", 32'(expQ.size()), 32'd0);

    applyStimulus(8, 1'b0, sc);
    checkOutput("start_clears_error", 32'({error, busy, den}), 32'b011);
    for (int k = 0; k < 2*N; k++) serve(1, 1'b1, 1'b0, dcyc, sdi);
    waitDone(dc);
    checkOutput("recover_error", 32'(error), 32'd0);

    // Asynchronous reset while waiting for the entry-0 read.
    applyStimulus(1, 1'b0, sc);
    serve(0, 1'b0, 1'b0, dcyc, sdi);
    @(posedge clkin);
    #1;
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outs", 32'({daddr, di, den, dwe, busy, done, error}), 32'd0);
    repeat (2) @(posedge clkin);
    #1;
    reset_n = 1'b1;
    n0 = denCount;
    d0 = doneCount;
    @(posedge clkin);
    #1;
    drdy = 1'b1;
    @(posedge clkin);
    #1;
    drdy = 1'b0;
    repeat (15) @(posedge clkin);
    #1;
    checkOutput("post_reset_dens", 32'(denCount - n0), 32'd0);
    checkOutput("post_reset_dones", 32'(doneCount - d0), 32'd0);
    checkOutput("post_reset_outs", 32'({daddr, di, den, dwe, busy, done, error}), 32'd0);
    checkOutput("reset_sb_empty", 32'(expQ.size()), 32'd0);

    // A fresh sequence after reset starts again from entry 0.
    n0 = denCount;
    applyStimulus(8, 1'b0, sc);
    for (int k = 0; k < 2*N; k++) serve(1, 1'b1, 1'b0, dcyc, sdi);
    waitDone(dc);
    checkOutput("final_latency", 32'(dc - sc), 32'(4*N + 1));
    #1;
    checkOutput("final_dens", 32'(denCount - n0), 32'(2*N));
    checkOutput("final_sb_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
